program_memory_fetch: RTL and testbench
=======================================

# program_memory_fetch

Instruction-memory side of the program sequencer interface. Takes the sequencer's combinational `pm_addr`, performs a registered read of a 256 x 8 program memory into `ir`, and decodes `ir` into the sequencer's control strobes (`jmp`, `jmp_nz`, `jmp_addr`, `NOP*`). It also owns program loading through a valid/ready write port and holds the sequencer in `sync_reset` until loading is complete.

## Interface
- `MEM_DEPTH`, 256: program memory words. Fixed at 256 because `pm_addr` is 8 bits.
- `NOP_WORD`, 8'h80: value forced into `ir` while not running.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pm_addr`  in  8  next fetch address from the program sequencer.
- `load_valid`  in  1  load write request.
- `load_addr`  in  8  memory address for a load write.
- `load_data`  in  8  instruction word for a load write.
- `load_done`  in  1  end-of-load strobe.
- `load_req`  in  1  request to return from RUN to LOAD.
- `load_ready`  out  1  high in LOAD; a write is accepted when `load_valid & load_ready`.
- `sync_reset`  out  1  to the sequencer; high whenever state != RUN.
- `ir`  out  8  current instruction register.
- `jmp`, `jmp_nz`  out  1 each  decoded jump strobes.
- `jmp_addr`  out  4  jump target nibble.
- `NOPC8`, `NOPCF`, `NOPD8`, `NOPDF`  out  1 each  decoded special opcodes.
- `load_count`  out  8  accepted writes since entering LOAD; saturates at 255.
- `load_sum`  out  8  sum of accepted `load_data`, mod 256.

## Operation
- **States:** LOAD (reset state) and RUN.
  - LOAD -> RUN when `load_done=1` and `load_valid=0` in the same cycle.
  - `load_done` is ignored while `load_valid=1`; the write has priority.
  - RUN -> LOAD when `load_req=1`. `load_req` is ignored in LOAD.
- **LOAD:**
  - `load_ready=1`.
  - An accepted write stores `mem[load_addr] <= load_data`, increments `load_count` (saturating at 255), and adds `load_data` to `load_sum` (8-bit wrap).
  - Entering LOAD from RUN clears `load_count` and `load_sum` and keeps memory contents.
  - Writes to the same address overwrite the earlier value; the last write wins.
- **RUN:**
  - `load_ready=0`; `load_valid` is ignored, so memory is unchanged.
- **IR register:**
  - Next state RUN: `ir <= mem[pm_addr]`.
  - Otherwise: `ir <= NOP_WORD`.
  - Because `sync_reset` forces `pm_addr=0` in the sequencer, the first `ir` loaded in RUN is `mem[0]`, aligned with `pc=0`.
- **Decode** (combinational from `ir`):
  - `jmp = (ir[7:4]==4'hE)`.
  - `jmp_nz = (ir[7:4]==4'hF)`.
  - `jmp_addr = ir[3:0]`.
  - `NOPC8 = (ir==8'hC8)`, `NOPCF = (ir==8'hCF)`, `NOPD8 = (ir==8'hD8)`, `NOPDF = (ir==8'hDF)`.
  - `ir[7:5]==3'b000` (jsr) is decoded by the sequencer, not here.
  - With `ir=NOP_WORD`, every decode output is 0.
- **Async reset** (any time, including mid-load or mid-run):
  - state=LOAD, `ir=NOP_WORD`, `load_count=0`, `load_sum=0`.
  - Resulting outputs: `sync_reset=1`, `load_ready=1`, all strobes 0.
  - Memory is not cleared.

## Timing
- Write latency: a write accepted at edge N is readable by a fetch at edge N+1 or later.
- Fetch latency: one cycle. `ir` at cycle N+1 = `mem[pm_addr at cycle N]`.
- LOAD->RUN: on the edge sampling `load_done`, state becomes RUN, `sync_reset` falls, and `ir` becomes `mem[0]`.
- RUN->LOAD: on the edge sampling `load_req`, `sync_reset` rises and `ir` becomes `NOP_WORD`. No fetch occurs that edge.
- Decode outputs change in the same cycle as `ir`, with no extra register.
- No bubbles: in RUN, one fetch per cycle.

## Test plan
- **Reset values:** assert `reset_n=0` mid-run. Expect immediately `sync_reset=1`, `load_ready=1`, `ir=8'h80`, all strobes 0, `load_count=0`, `load_sum=0`.
- **Load and run:** write {0:8'h20, 1:8'hE3, 0x30:8'hC8}, then `load_done`. Expect `load_count=3`, `load_sum=8'hCB`. First RUN cycle `ir=8'h20`. Next cycle `ir=8'hE3` with `jmp=1`, `jmp_addr=3`.
- **Priority:** `load_valid=1` and `load_done=1` together with addr 5, data 8'hF2. Expect the write accepted and state still LOAD. `load_done` alone on the next cycle starts RUN.
- **Decode sweep:** load and fetch 8'hC8, 8'hCF, 8'hD8, 8'hDF, 8'hF7, 8'hE0. Expect exactly one matching strobe per word. 8'hF7 gives `jmp_nz=1`, `jmp_addr=7`.
- **Ignored write / reload:** in RUN, `load_valid` to addr 0 has no effect (re-fetch of addr 0 unchanged). Then `load_req` gives `sync_reset=1`, `load_count=0`, `ir=8'h80`, and prior memory is retained.
- **Saturation:** 300 accepted writes. Expect `load_count=255`, `load_sum` = byte sum mod 256, addresses wrapping 0..255.

Source files
------------

// File: rtl/program_memory_fetch_if.sv
// Program-load write port: valid/ready handshake carrying address and data.
// The master drives a write; the slave accepts it when ready is high.
interface program_memory_fetch_if;
    logic       valid;
    logic       ready;
    logic [7:0] addr;
    logic [7:0] data;

    modport master (output valid, addr, data, input ready);
    modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/program_memory_fetch.sv
// Program memory, load port and instruction fetch/decode for the sequencer.
// Holds the sequencer in sync_reset until a program has been loaded.
module program_memory_fetch #(
    parameter int         MEM_DEPTH = 256,
    parameter logic [7:0] NOP_WORD  = 8'h80
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [7:0]                   pm_addr,
    input  logic                         load_done,
    input  logic                         load_req,
    program_memory_fetch_if.slave        load,
    output logic                         sync_reset,
    output logic [7:0]                   ir,
    output logic                         jmp,
    output logic                         jmp_nz,
    output logic [3:0]                   jmp_addr,
    output logic                         NOPC8,
    output logic                         NOPCF,
    output logic                         NOPD8,
    output logic                         NOPDF,
    output logic [7:0]                   load_count,
    output logic [7:0]                   load_sum
);

    typedef enum logic {LOAD, RUN} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       wr_en;
    logic       clr;
    logic [7:0] mem [MEM_DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= LOAD;
        else          state <= state_nxt;
    end

    // A pending write always wins over load_done.
    always_comb begin
        state_nxt  = state;
        load.ready = 1'b0;
        sync_reset = 1'b1;
        wr_en      = 1'b0;
        clr        = 1'b0;
        unique case (state)
            LOAD: begin
                load.ready = 1'b1;
                wr_en      = load.valid;
                if (load_done && !load.valid) state_nxt = RUN;
            end
            RUN: begin
                sync_reset = 1'b0;
                if (load_req) begin
                    state_nxt = LOAD;
                    clr       = 1'b1;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[load.addr] <= load.data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ir <= NOP_WORD;
        else if (state_nxt == RUN)
            ir <= mem[pm_addr];
        else
            ir <= NOP_WORD;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_count <= 8'd0;
            load_sum   <= 8'd0;
        end else if (clr) begin
            load_count <= 8'd0;
            load_sum   <= 8'd0;
        end else if (wr_en) begin
            if (load_count != 8'hFF) load_count <= load_count + 8'd1;
            load_sum <= load_sum + load.data;
        end
    end

    assign jmp      = (ir[7:4] == 4'hE);
    assign jmp_nz   = (ir[7:4] == 4'hF);
    assign jmp_addr = ir[3:0];
    assign NOPC8    = (ir == 8'hC8);
    assign NOPCF    = (ir == 8'hCF);
    assign NOPD8    = (ir == 8'hD8);
    assign NOPDF    = (ir == 8'hDF);

endmodule

// File: tb/tb_program_memory_fetch.sv
// Randomised bench for program_memory_fetch with a behavioural model
// and directed literal checks of load, fetch, decode and reload.
module tb_program_memory_fetch;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] pm_addr = 8'd0;
    logic       load_done = 1'b0;
    logic       load_req = 1'b0;
    logic       sync_reset;
    logic [7:0] ir;
    logic       jmp, jmp_nz;
    logic [3:0] jmp_addr;
    logic       NOPC8, NOPCF, NOPD8, NOPDF;
    logic [7:0] load_count, load_sum;

    program_memory_fetch_if lif ();

    program_memory_fetch dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pm_addr    (pm_addr),
        .load_done  (load_done),
        .load_req   (load_req),
        .load       (lif),
        .sync_reset (sync_reset),
        .ir         (ir),
        .jmp        (jmp),
        .jmp_nz     (jmp_nz),
        .jmp_addr   (jmp_addr),
        .NOPC8      (NOPC8),
        .NOPCF      (NOPCF),
        .NOPD8      (NOPD8),
        .NOPDF      (NOPDF),
        .load_count (load_count),
        .load_sum   (load_sum)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit checking = 1'b0;

    // Reference model: program memory, run flag, ir, counters.
    logic [7:0] m_mem [256];
    bit         m_run = 1'b0;
    logic [7:0] m_ir = 8'h80;
    int         m_cnt = 0;
    logic [7:0] m_sum = 8'd0;

    initial for (int i = 0; i < 256; i++) m_mem[i] = 8'd0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 1'b0;
            m_ir  = 8'h80;
            m_cnt = 0;
            m_sum = 8'd0;
        end else if (m_run) begin
            if (load_req) begin
                m_run = 1'b0;
                m_ir  = 8'h80;
                m_cnt = 0;
                m_sum = 8'd0;
            end else begin
                m_ir = m_mem[pm_addr];
            end
        end else begin
            if (lif.valid) begin
                m_mem[lif.addr] = lif.data;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
                m_sum = m_sum + lif.data;
                m_ir  = 8'h80;
            end else if (load_done) begin
                m_run = 1'b1;
                m_ir  = m_mem[pm_addr];
            end else begin
                m_ir = 8'h80;
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {NOPC8, NOPCF, NOPD8, NOPDF, jmp_nz, jmp};
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            chk("sync_reset", {7'd0, sync_reset}, {7'd0, !m_run});
            chk("load_ready", {7'd0, lif.ready}, {7'd0, !m_run});
            chk("ir", ir, m_ir);
            chk("jmp", {7'd0, jmp}, {7'd0, m_ir[7:4] == 4'hE});
            chk("jmp_nz", {7'd0, jmp_nz}, {7'd0, m_ir[7:4] == 4'hF});
            chk("jmp_addr", {4'd0, jmp_addr}, {4'd0, m_ir[3:0]});
            chk("nopc8", {7'd0, NOPC8}, {7'd0, m_ir == 8'hC8});
            chk("nopcf", {7'd0, NOPCF}, {7'd0, m_ir == 8'hCF});
            chk("nopd8", {7'd0, NOPD8}, {7'd0, m_ir == 8'hD8});
            chk("nopdf", {7'd0, NOPDF}, {7'd0, m_ir == 8'hDF});
            chk("load_count", load_count, m_cnt[7:0]);
            chk("load_sum", load_sum, m_sum);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write(input logic [7:0] a, input logic [7:0] d,
                         input bit done);
        lif.valid = 1'b1;
        lif.addr  = a;
        lif.data  = d;
        load_done = done;
        tick();
        lif.valid = 1'b0;
        load_done = 1'b0;
    endtask

    logic [7:0] words [6];
    logic [7:0] s8;
    logic [7:0] d, first_word;

    initial begin
        lif.valid = 1'b0;
        lif.addr  = 8'd0;
        lif.data  = 8'd0;
        words = '{8'hC8, 8'hCF, 8'hD8, 8'hDF, 8'hF7, 8'hE0};
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        checking = 1'b1;
        tick();
        chk("rst_sync_reset", {7'd0, sync_reset}, 8'd1);
        chk("rst_ir", ir, 8'h80);

        // Saturation: 300 writes wrapping the address space.
        s8 = 8'd0;
        first_word = 8'd0;
        for (int i = 0; i < 300; i++) begin
            d = 8'($urandom);
            if (i == 256) first_word = d;
            s8 = s8 + d;
            write(8'(i % 256), d, 1'b0);
        end
        chk("sat_count", load_count, 8'd255);
        chk("sat_sum", load_sum, s8);

        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        chk("first_fetch", ir, first_word);

        for (int i = 0; i < 60; i++) begin
            pm_addr   = 8'($urandom);
            lif.valid = 1'($urandom);
            lif.addr  = 8'($urandom);
            lif.data  = 8'($urandom);
            tick();
        end
        lif.valid = 1'b0;

        // Asynchronous reset mid-run.
        #2 reset_n = 1'b0;
        #1;
        chk("arst_sync_reset", {7'd0, sync_reset}, 8'd1);
        chk("arst_load_ready", {7'd0, lif.ready}, 8'd1);
        chk("arst_ir", ir, 8'h80);
        chk("arst_strobes", {2'd0, strobes()}, 8'd0);
        chk("arst_count", load_count, 8'd0);
        chk("arst_sum", load_sum, 8'd0);
        pm_addr = 8'd0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Load and run.
        write(8'h00, 8'h20, 1'b0);
        write(8'h01, 8'hE3, 1'b0);
        write(8'h30, 8'hC8, 1'b0);
        chk("lr_count", load_count, 8'd3);
        chk("lr_sum", load_sum, 8'hCB);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        chk("lr_ir0", ir, 8'h20);
        chk("lr_sync_reset", {7'd0, sync_reset}, 8'd0);
        pm_addr = 8'd1;
        tick();
        chk("lr_ir1", ir, 8'hE3);
        chk("lr_jmp", {7'd0, jmp}, 8'd1);
        chk("lr_jmp_addr", {4'd0, jmp_addr}, 8'd3);

        // Ignored write in RUN.
        pm_addr   = 8'd0;
        lif.valid = 1'b1;
        lif.addr  = 8'd0;
        lif.data  = 8'h55;
        tick();
        lif.valid = 1'b0;
        tick();
        chk("ign_ir", ir, 8'h20);

        // Reload request.
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        chk("rl_sync_reset", {7'd0, sync_reset}, 8'd1);
        chk("rl_count", load_count, 8'd0);
        chk("rl_ir", ir, 8'h80);

        // Write has priority over load_done.
        write(8'h05, 8'hF2, 1'b1);
        chk("pri_ready", {7'd0, lif.ready}, 8'd1);
        chk("pri_count", load_count, 8'd1);
        chk("pri_sum", load_sum, 8'hF2);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        chk("pri_run", {7'd0, sync_reset}, 8'd0);
        chk("pri_ir0", ir, 8'h20);
        pm_addr = 8'h05;
        tick();
        chk("pri_ir5", ir, 8'hF2);
        chk("pri_jmp_nz", {7'd0, jmp_nz}, 8'd1);
        chk("pri_jmp_addr", {4'd0, jmp_addr}, 8'd2);
        pm_addr = 8'h30;
        tick();
        chk("keep_ir30", ir, 8'hC8);
        chk("keep_nopc8", {7'd0, NOPC8}, 8'd1);

        // Decode sweep.
        load_req = 1'b1;
        pm_addr  = 8'd0;
        tick();
        load_req = 1'b0;
        for (int i = 0; i < 6; i++) write(8'(8'h40 + i), words[i], 1'b0);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pm_addr = 8'(8'h40 + i);
            tick();
            chk("dec_strobes", {2'd0, strobes()}, {2'd0, 6'b100000 >> i});
            if (i == 4) chk("dec_f7_addr", {4'd0, jmp_addr}, 8'd7);
        end

        // Random mixed traffic.
        for (int i = 0; i < 800; i++) begin
            lif.addr = 8'($urandom);
            lif.data = 8'($urandom);
            if (m_run) begin
                pm_addr   = 8'($urandom);
                lif.valid = 1'($urandom);
                load_req  = ($urandom % 20) == 0;
                load_done = 1'($urandom);
            end else begin
                pm_addr   = 8'd0;
                lif.valid = ($urandom % 3) != 0;
                load_done = ($urandom % 8) == 0;
                load_req  = 1'($urandom);
            end
            tick();
        end
        lif.valid = 1'b0;
        load_done = 1'b0;
        load_req  = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
